// File: rtl/polyphase_decim_fir_pkg.sv
// Shared sizing helpers and the round/saturate function for the polyphase decimating FIR.
package polyphase_decim_fir_pkg;

  typedef logic signed [63:0] wide_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned coef_w,
                                            input int unsigned taps);
    return data_w + coef_w + clog2(taps);
  endfunction

  // Round half up, then clamp to the signed out_w range; sat reports a clamp.
  function automatic wide_t round_sat(input wide_t y, input int unsigned shift,
                                      input int unsigned out_w, output logic sat);
    wide_t bias;
    wide_t r;
    wide_t max_v;
    wide_t min_v;
    bias  = (shift == 0) ? '0 : (wide_t'(1) <<< (shift - 1));
    r     = (y + bias) >>> shift;
    max_v = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
    min_v = -(wide_t'(1) <<< (out_w - 1));
    sat   = 1'b0;
    if (r > max_v) begin
      r   = max_v;
      sat = 1'b1;
    end else if (r < min_v) begin
      r   = min_v;
      sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/polyphase_decim_fir_branch.sv
// One polyphase branch: registered T-tap products and their combinational sum.
module polyphase_branch
  import polyphase_decim_fir_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 12,
  parameter int unsigned TAPS   = 4,
  parameter int unsigned ACC_W  = 25
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x_tap [TAPS],
  input  logic signed [COEF_W-1:0] c_tap [TAPS],
  output logic signed [ACC_W-1:0]  sum
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod_q [TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < int'(TAPS); t++) prod_q[t] <= '0;
    end else if (en) begin
      for (int t = 0; t < int'(TAPS); t++) prod_q[t] <= PROD_W'(x_tap[t]) * PROD_W'(c_tap[t]);
    end
  end

  always_comb begin
    sum = '0;
    for (int t = 0; t < int'(TAPS); t++) sum = sum + ACC_W'(prod_q[t]);
  end

endmodule

// File: rtl/polyphase_decim_fir.sv
// Polyphase decimating FIR: commutator, sample history, coefficient bank, adder tree, round/sat.
module polyphase_decim_fir
  import polyphase_decim_fir_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned COEF_W         = 12,
  parameter int unsigned OUT_W          = 8,
  parameter int unsigned PHASES         = 8,
  parameter int unsigned TAPS_PER_PHASE = 4,
  parameter int unsigned SHIFT          = 11,
  localparam int unsigned N             = PHASES * TAPS_PER_PHASE,
  localparam int unsigned ADDR_W        = clog2(N),
  localparam int unsigned PHASE_W       = clog2(PHASES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     flush,
  input  logic                     coef_we,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     sat_flag,
  output logic [PHASE_W-1:0]       phase
);

  localparam int unsigned ACC_W = acc_width(DATA_W, COEF_W, N);

  logic signed [DATA_W-1:0] hist_q [N];
  logic signed [DATA_W-1:0] hist_d [N];
  logic signed [COEF_W-1:0] coef_q [N];
  logic [PHASE_W-1:0]       phase_q, phase_d;
  logic                     accept, frame_done;

  logic signed [ACC_W-1:0]  branch_sum [PHASES];
  logic signed [ACC_W-1:0]  tree_sum, sum_q;
  logic                     prod_valid_q, sum_valid_q;
  logic                     out_valid_q, sat_q, sat_d, clamp;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;

  always_comb begin
    accept     = in_valid & ~flush;
    frame_done = accept && (phase_q == PHASE_W'(PHASES - 1));
    hist_d     = hist_q;
    phase_d    = phase_q;
    if (flush) begin
      for (int n = 0; n < int'(N); n++) hist_d[n] = '0;
      phase_d = '0;
    end else if (in_valid) begin
      hist_d[0] = in_data;
      for (int n = 1; n < int'(N); n++) hist_d[n] = hist_q[n-1];
      phase_d = frame_done ? '0 : phase_q + PHASE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < int'(N); n++) begin
        hist_q[n] <= '0;
        coef_q[n] <= '0;
      end
      phase_q <= '0;
    end else begin
      hist_q  <= hist_d;
      phase_q <= phase_d;
      if (coef_we && (32'(coef_addr) < N)) coef_q[coef_addr] <= coef_wdata;
    end
  end

  // Products are captured from the next-state history and current coefficients, so a
  // coefficient write on the frame-completing edge only affects later frames.
  for (genvar p = 0; p < int'(PHASES); p++) begin : g_branch
    logic signed [DATA_W-1:0] x_tap [TAPS_PER_PHASE];
    logic signed [COEF_W-1:0] c_tap [TAPS_PER_PHASE];

    always_comb begin
      for (int t = 0; t < int'(TAPS_PER_PHASE); t++) begin
        x_tap[t] = hist_d[p + t * int'(PHASES)];
        c_tap[t] = coef_q[p + t * int'(PHASES)];
      end
    end

    polyphase_branch #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .TAPS   (TAPS_PER_PHASE),
      .ACC_W  (ACC_W)
    ) u_branch (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (frame_done),
      .x_tap (x_tap),
      .c_tap (c_tap),
      .sum   (branch_sum[p])
    );
  end

  always_comb begin
    tree_sum = '0;
    for (int p = 0; p < int'(PHASES); p++) tree_sum = tree_sum + branch_sum[p];
  end

  always_comb begin
    clamp      = 1'b0;
    out_data_d = OUT_W'(round_sat(64'(sum_q), SHIFT, OUT_W, clamp));
    sat_d      = sat_q;
    if (flush) sat_d = 1'b0;
    else if (sum_valid_q && clamp) sat_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_valid_q <= 1'b0;
      sum_valid_q  <= 1'b0;
      sum_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      sat_q        <= 1'b0;
    end else begin
      prod_valid_q <= frame_done;
      sum_valid_q  <= prod_valid_q;
      if (prod_valid_q) sum_q <= tree_sum;
      out_valid_q  <= sum_valid_q;
      if (sum_valid_q) out_data_q <= out_data_d;
      sat_q        <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_flag  = sat_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_polyphase_decim_fir.sv
// Directed bench for polyphase_decim_fir: default instance plus a wide, unshifted instance.
module tb_polyphase_decim_fir;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [7:0]  in_data = '0;
  logic               flush = 1'b0;
  logic               coef_we = 1'b0;
  logic [4:0]         coef_addr = '0;
  logic signed [11:0] coef_wdata = '0;

  logic               ov, sf, ov16, sf16;
  logic signed [7:0]  od;
  logic signed [15:0] od16;
  logic [2:0]         ph, ph16;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  longint q8[$], q16[$];
  int c8[$], c16[$];
  int edges[$];

  polyphase_decim_fir dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(ov), .out_data(od), .sat_flag(sf), .phase(ph)
  );

  polyphase_decim_fir #(.OUT_W(16), .SHIFT(0)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(ov16), .out_data(od16), .sat_flag(sf16), .phase(ph16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ov) begin q8.push_back(od); c8.push_back(cyc); end
    if (ov16) begin q16.push_back(od16); c16.push_back(cyc); end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push(input logic signed [7:0] x);
    in_valid = 1'b1;
    in_data  = x;
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wcoef(input int a, input int v);
    coef_we    = 1'b1;
    coef_addr  = 5'(a);
    coef_wdata = 12'(v);
    step();
    coef_we = 1'b0;
  endtask

  task automatic clearq();
    q8.delete(); q16.delete(); c8.delete(); c16.delete(); edges.delete();
  endtask

  function automatic longint q8_at(input int i);
    return (i < q8.size()) ? q8[i] : -99999;
  endfunction

  function automatic longint q16_at(input int i);
    return (i < q16.size()) ? q16[i] : -99999;
  endfunction

  // Reference for the gap test: c[n]=n+1, x(j)=j-8, zero before the first sample.
  function automatic longint model(input int f);
    longint y = 0;
    for (int n = 0; n < 32; n++) begin
      int j = 8 * f + 7 - n;
      if (j >= 0) y += longint'(n + 1) * longint'(j - 8);
    end
    return y;
  endfunction

  initial begin
    // Reset state
    #2;
    check_eq("rst ov", ov, 0);
    check_eq("rst od", od, 0);
    check_eq("rst sf", sf, 0);
    check_eq("rst ph", ph, 0);
    #10 rst_n = 1'b1;
    step();

    // Polyphase ordering on the wide instance
    for (int n = 0; n < 32; n++) wcoef(n, n + 1);
    do_flush();
    clearq();
    for (int i = 0; i < 40; i++) begin
      push((i == 0) ? 8'sd1 : 8'sd0);
      if (i % 8 == 7) edges.push_back(cyc);
    end
    idle(3);
    check_eq("order count", q16.size(), 5);
    for (int j = 0; j < 5; j++) begin
      check_eq($sformatf("order out%0d", j), q16_at(j), (j < 4) ? 8 * (j + 1) : 0);
      check_eq($sformatf("order lat%0d", j), (j < c16.size()) ? c16[j] : -1, edges[j] + 2);
    end

    // DC gain
    for (int n = 0; n < 32; n++) wcoef(n, 64);
    do_flush();
    clearq();
    repeat (40) push(8'sd100);
    idle(3);
    check_eq("dc frame1", q8_at(0), 25);
    check_eq("dc frame4", q8_at(3), 100);
    check_eq("dc frame5", q8_at(4), 100);
    check_eq("dc sat", sf, 0);

    // Saturation and flush clearing of sat_flag
    for (int n = 0; n < 32; n++) wcoef(n, 2047);
    do_flush();
    clearq();
    repeat (8) push(8'sd127);
    idle(3);
    check_eq("sat pos out", q8_at(0), 127);
    check_eq("sat pos flag", sf, 1);
    do_flush();
    check_eq("sat flush clr", sf, 0);
    clearq();
    repeat (8) push(-8'sd128);
    idle(3);
    check_eq("sat neg out", q8_at(0), -128);
    check_eq("sat neg flag", sf, 1);
    do_flush();
    check_eq("sat flush only", sf, 0);

    // Asynchronous reset mid-frame
    repeat (8) push(-8'sd128);
    repeat (3) push(8'sd5);
    check_eq("pre-rst ph", ph, 3);
    check_eq("pre-rst sf", sf, 1);
    rst_n = 1'b0;
    #2;
    check_eq("midrst ph", ph, 0);
    check_eq("midrst od", od, 0);
    check_eq("midrst sf", sf, 0);
    check_eq("midrst ov", ov, 0);
    #1 rst_n = 1'b1;
    clearq();
    repeat (7) push(8'sd9);
    idle(4);
    check_eq("postrst none", q8.size(), 0);
    push(8'sd9);
    edges.push_back(cyc);
    idle(3);
    check_eq("postrst one", q8.size(), 1);
    check_eq("postrst lat", (c8.size() > 0) ? c8[0] : -1, edges[0] + 2);

    // Rounding: c[0]=1024
    for (int n = 0; n < 32; n++) wcoef(n, (n == 0) ? 1024 : 0);
    do_flush();
    clearq();
    repeat (7) push(8'sd0);
    push(8'sd3);
    repeat (7) push(8'sd0);
    push(-8'sd3);
    repeat (7) push(8'sd0);
    push(8'sd4);
    idle(3);
    check_eq("round +3", q8_at(0), 2);
    check_eq("round -3", q8_at(1), -1);
    check_eq("round +4", q8_at(2), 2);
    idle(5);
    check_eq("hold od", od, 2);
    check_eq("hold ov", ov, 0);

    // Gap-free vs gapped input
    for (int n = 0; n < 32; n++) wcoef(n, n + 1);
    do_flush();
    clearq();
    for (int i = 0; i < 24; i++) push(8'(i - 8));
    idle(3);
    for (int f = 0; f < 3; f++) check_eq($sformatf("nogap f%0d", f), q16_at(f), model(f));
    do_flush();
    clearq();
    for (int i = 0; i < 24; i++) begin
      in_data = 8'($urandom);
      idle($urandom_range(0, 3));
      push(8'(i - 8));
    end
    idle(3);
    check_eq("gap count", q16.size(), 3);
    for (int f = 0; f < 3; f++) check_eq($sformatf("gap f%0d", f), q16_at(f), model(f));

    // Flush racing in_valid at phase 5
    do_flush();
    clearq();
    repeat (5) push(8'sd7);
    check_eq("race ph5", ph16, 5);
    flush = 1'b1;
    push(8'sd99);
    flush = 1'b0;
    check_eq("race ph0", ph16, 0);
    repeat (7) push(8'sd0);
    push(8'sd1);
    idle(3);
    check_eq("race drop", q16_at(0), 1);

    // Coefficient write on the frame-completing edge
    do_flush();
    clearq();
    repeat (7) push(8'sd0);
    coef_we    = 1'b1;
    coef_addr  = 5'd0;
    coef_wdata = 12'sd100;
    push(8'sd1);
    coef_we = 1'b0;
    repeat (7) push(8'sd0);
    push(8'sd1);
    idle(3);
    check_eq("wr old c", q16_at(0), 1);
    check_eq("wr new c", q16_at(1), 109);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
